instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 31 +++
 rtl/if_id_register.sv | 55 +++++
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared definitions for the instruction fetch stage: opcode
//               constants, the bubble word and the fetch FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

  // Width of the word consumed by the decode stage
  localparam int INSTR_LEN = 20;

  // Opcode field lives in the top nibble of the instruction word
  localparam logic [3:0] OP_STORE = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // A bubble is an all-zero instruction slot
  localparam logic [INSTR_LEN-1:0] BUBBLE_WORD = '0;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

  function automatic logic is_halt(input logic [3:0] opcode);
    return (opcode == OP_HALT);
  endfunction

endpackage : instruction_fetch_pkg
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// ============================================================================
// Module      : if_id_register
// Description : IF/ID pipeline register holding the fetched instruction, its
//               PC and a valid flag. Priority: reset > clear > load > hold.
// Ports       : i_clk    - clock
//               i_rst    - synchronous active-high reset
//               i_load   - capture i_instr/i_pc as a valid entry
//               i_clear  - replace contents with a bubble
//               i_instr  - instruction word to capture
//               i_pc     - PC of that instruction
//               o_instr  - registered instruction
//               o_pc     - registered PC
//               o_valid  - 1 = real instruction, 0 = bubble
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_register
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_instr <= INSTR_W'(BUBBLE_WORD);
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule : if_id_register
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Instruction fetch stage. Owns the PC and a RUN/HALTED FSM,
//               reads an external combinational instruction memory and
//               feeds the IF/ID pipeline register. Per-cycle priority is
//               reset > branchTaken > stall > normal advance.
// Ports       : clock            - clock, rising edge active
//               reset            - synchronous active-high reset
//               stall            - hold request from downstream
//               branchTaken      - redirect request from execute
//               branchTarget     - redirect address
//               imemAddress      - instruction memory address (= PC)
//               imemData         - instruction word at imemAddress
//               instruction      - IF/ID instruction
//               pcPropagation    - PC of the IF/ID instruction
//               instructionValid - IF/ID holds a real instruction
//               halted           - FSM is in HALTED
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               branchTaken,
  input  logic [ADDR_W-1:0]  branchTarget,
  output logic [ADDR_W-1:0]  imemAddress,
  input  logic [INSTR_W-1:0] imemData,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pcPropagation,
  output logic               instructionValid,
  output logic               halted
);

  logic [ADDR_W-1:0] r_pc;
  fetch_state_t      r_state;

  logic [ADDR_W-1:0] w_pc_next;
  fetch_state_t      w_state_next;
  logic              w_load;
  logic              w_clear;
  logic [3:0]        w_opcode;

  // Only the opcode nibble is inspected; everything else passes through
  assign w_opcode = imemData[INSTR_W-1 -: 4];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc    <= '0;
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_pc_next;
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_pc_next    = r_pc;
    w_state_next = r_state;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    if (branchTaken) begin
      // Redirect wins over stall and also leaves HALTED
      w_pc_next    = branchTarget;
      w_clear      = 1'b1;
      w_state_next = ST_RUN;
    end else if (stall) begin
      // everything holds
    end else if (r_state == ST_RUN) begin
      w_load = 1'b1;
      if (is_halt(w_opcode)) begin
        // HALT is delivered to decode but the PC parks on it
        w_state_next = ST_HALTED;
      end else begin
        w_pc_next = r_pc + ADDR_W'(1);
      end
    end else begin
      // HALTED: keep issuing bubbles until redirected or reset
      w_clear = 1'b1;
    end
  end

  if_id_register #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_load  (w_load),
    .i_clear (w_clear),
    .i_instr (imemData),
    .i_pc    (r_pc),
    .o_instr (instruction),
    .o_pc    (pcPropagation),
    .o_valid (instructionValid)
  );

  assign imemAddress = r_pc;
  assign halted      = (r_state == ST_HALTED);

endmodule : instruction_fetch
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch. A combinational
//               ROM models instruction memory; per-cycle vectors carry the
//               inputs and the expected post-edge outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 20;

  typedef struct {
    logic               rst;
    logic               stall;
    logic               br;
    logic [ADDR_W-1:0]  tgt;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic               valid;
    logic               hlt;
    logic [ADDR_W-1:0]  addr;
  } vec_t;

  logic               clock;
  logic               reset;
  logic               stall;
  logic               branchTaken;
  logic [ADDR_W-1:0]  branchTarget;
  logic [ADDR_W-1:0]  imemAddress;
  logic [INSTR_W-1:0] imemData;
  logic [INSTR_W-1:0] instruction;
  logic [ADDR_W-1:0]  pcPropagation;
  logic               instructionValid;
  logic               halted;

  logic [INSTR_W-1:0] rom [0:255];

  int   n_checks;
  int   n_fail;
  vec_t sb[$];
  vec_t tbl[21];

  instruction_fetch #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .branchTaken      (branchTaken),
    .branchTarget     (branchTarget),
    .imemAddress      (imemAddress),
    .imemData         (imemData),
    .instruction      (instruction),
    .pcPropagation    (pcPropagation),
    .instructionValid (instructionValid),
    .halted           (halted)
  );

  assign imemData = rom[imemAddress];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic stl, input logic br,
                              input logic [ADDR_W-1:0] tgt,
                              input logic [INSTR_W-1:0] instr,
                              input logic [ADDR_W-1:0] pc, input logic valid,
                              input logic hlt, input logic [ADDR_W-1:0] addr);
    vec_t v;
    v.rst = rst; v.stall = stl; v.br = br; v.tgt = tgt;
    v.instr = instr; v.pc = pc; v.valid = valid; v.hlt = hlt; v.addr = addr;
    return v;
  endfunction

  task automatic chk(input string name, input int cyc,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge
  task automatic step(input vec_t v, input int cyc);
    vec_t e;
    @(negedge clock);
    reset        = v.rst;
    stall        = v.stall;
    branchTaken  = v.br;
    branchTarget = v.tgt;
    sb.push_back(v);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("instruction",      cyc, 32'(instruction),      32'(e.instr));
    chk("pcPropagation",    cyc, 32'(pcPropagation),    32'(e.pc));
    chk("instructionValid", cyc, 32'(instructionValid), 32'(e.valid));
    chk("halted",           cyc, 32'(halted),           32'(e.hlt));
    chk("imemAddress",      cyc, 32'(imemAddress),      32'(e.addr));
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    stall        = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = '0;

    for (int i = 0; i < 256; i++) rom[i] = 20'h30000 + INSTR_W'(i);
    rom[8'h00] = 20'h1A2B3;
    rom[8'h01] = 20'hC0F00;   // STORE passes through untouched
    rom[8'h02] = 20'h21110;
    rom[8'h05] = 20'hF0000;   // HALT
    rom[8'hFF] = 20'h12345;

    //            rst  stl  br   tgt    instr      pc     v     h     addr
    tbl[0]  = mk(1'b1,1'b0,1'b0,8'h00,20'h00000,8'h00,1'b0,1'b0,8'h00);
    tbl[1]  = mk(1'b0,1'b0,1'b0,8'h00,20'h1A2B3,8'h00,1'b1,1'b0,8'h01);
    tbl[2]  = mk(1'b0,1'b0,1'b0,8'h00,20'hC0F00,8'h01,1'b1,1'b0,8'h02);
    tbl[3]  = mk(1'b0,1'b1,1'b0,8'h00,20'hC0F00,8'h01,1'b1,1'b0,8'h02);
    tbl[4]  = mk(1'b0,1'b1,1'b0,8'h00,20'hC0F00,8'h01,1'b1,1'b0,8'h02);
    tbl[5]  = mk(1'b0,1'b1,1'b0,8'h00,20'hC0F00,8'h01,1'b1,1'b0,8'h02);
    tbl[6]  = mk(1'b0,1'b0,1'b0,8'h00,20'h21110,8'h02,1'b1,1'b0,8'h03);
    tbl[7]  = mk(1'b0,1'b0,1'b0,8'h00,20'h30003,8'h03,1'b1,1'b0,8'h04);
    tbl[8]  = mk(1'b0,1'b0,1'b0,8'h00,20'h30004,8'h04,1'b1,1'b0,8'h05);
    // HALT at 5: latched valid, PC parks on the HALT word
    tbl[9]  = mk(1'b0,1'b0,1'b0,8'h00,20'hF0000,8'h05,1'b1,1'b1,8'h05);
    tbl[10] = mk(1'b0,1'b0,1'b0,8'h00,20'h00000,8'h00,1'b0,1'b1,8'h05);
    tbl[11] = mk(1'b0,1'b1,1'b0,8'h00,20'h00000,8'h00,1'b0,1'b1,8'h05);
    tbl[12] = mk(1'b0,1'b0,1'b0,8'h00,20'h00000,8'h00,1'b0,1'b1,8'h05);
    tbl[13] = mk(1'b0,1'b0,1'b1,8'h10,20'h00000,8'h00,1'b0,1'b0,8'h10);
    tbl[14] = mk(1'b0,1'b0,1'b0,8'h00,20'h30010,8'h10,1'b1,1'b0,8'h11);
    // branch beats a simultaneous stall
    tbl[15] = mk(1'b0,1'b1,1'b1,8'h40,20'h00000,8'h00,1'b0,1'b0,8'h40);
    tbl[16] = mk(1'b0,1'b0,1'b0,8'h00,20'h30040,8'h40,1'b1,1'b0,8'h41);
    tbl[17] = mk(1'b0,1'b0,1'b1,8'hFE,20'h00000,8'h00,1'b0,1'b0,8'hFE);
    tbl[18] = mk(1'b0,1'b0,1'b0,8'h00,20'h300FE,8'hFE,1'b1,1'b0,8'hFF);
    // PC wraps from FF to 00
    tbl[19] = mk(1'b0,1'b0,1'b0,8'h00,20'h12345,8'hFF,1'b1,1'b0,8'h00);
    tbl[20] = mk(1'b0,1'b0,1'b0,8'h00,20'h1A2B3,8'h00,1'b1,1'b0,8'h01);

    for (int i = 0; i < 21; i++) step(tbl[i], i);

    // Reset while HALTED, with stall and branch also asserted
    step(mk(1'b0,1'b0,1'b1,8'h05,20'h00000,8'h00,1'b0,1'b0,8'h05), 100);
    step(mk(1'b0,1'b0,1'b0,8'h00,20'hF0000,8'h05,1'b1,1'b1,8'h05), 101);
    step(mk(1'b0,1'b0,1'b0,8'h00,20'h00000,8'h00,1'b0,1'b1,8'h05), 102);
    step(mk(1'b1,1'b1,1'b1,8'h77,20'h00000,8'h00,1'b0,1'b0,8'h00), 103);
    step(mk(1'b0,1'b0,1'b0,8'h00,20'h1A2B3,8'h00,1'b1,1'b0,8'h01), 104);

    // Reset mid-run discards a valid IF/ID entry
    step(mk(1'b0,1'b0,1'b0,8'h00,20'hC0F00,8'h01,1'b1,1'b0,8'h02), 200);
    step(mk(1'b1,1'b0,1'b0,8'h00,20'h00000,8'h00,1'b0,1'b0,8'h00), 201);
    step(mk(1'b0,1'b0,1'b0,8'h00,20'h1A2B3,8'h00,1'b1,1'b0,8'h01), 202);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_instruction_fetch
`default_nettype wire
